// File: rtl/ifns_pkg.sv
// -----------------------------------------------------------------------------
// ifns_pkg
// Shared definitions for the IFNS 16-bit -> 23-bit crosstalk-avoidance coder:
//   IFNS_DATA_W / IFNS_CODE_W  raw segment and codeword widths
//   ifns_code_t                codeword type, bits [23:1] (bit i has weight F(i))
//   phase_e                    scheduler phase decoded from the remaining count
//   fib_weight()               Fibonacci weight of codeword bit i
// -----------------------------------------------------------------------------
package ifns_pkg;

  localparam int IFNS_DATA_W = 16;
  localparam int IFNS_CODE_W = 23;

  typedef logic [IFNS_CODE_W:1] ifns_code_t;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_BUSY = 2'd1,
    PH_LAST = 2'd2
  } phase_e;

  // Weights 1,2,3,5,8,... so 23 bits cover every 16-bit value (F(24)=75025).
  function automatic logic [15:0] fib_weight(input int unsigned i);
    case (i)
      32'd1:   fib_weight = 16'd1;
      32'd2:   fib_weight = 16'd2;
      32'd3:   fib_weight = 16'd3;
      32'd4:   fib_weight = 16'd5;
      32'd5:   fib_weight = 16'd8;
      32'd6:   fib_weight = 16'd13;
      32'd7:   fib_weight = 16'd21;
      32'd8:   fib_weight = 16'd34;
      32'd9:   fib_weight = 16'd55;
      32'd10:  fib_weight = 16'd89;
      32'd11:  fib_weight = 16'd144;
      32'd12:  fib_weight = 16'd233;
      32'd13:  fib_weight = 16'd377;
      32'd14:  fib_weight = 16'd610;
      32'd15:  fib_weight = 16'd987;
      32'd16:  fib_weight = 16'd1597;
      32'd17:  fib_weight = 16'd2584;
      32'd18:  fib_weight = 16'd4181;
      32'd19:  fib_weight = 16'd6765;
      32'd20:  fib_weight = 16'd10946;
      32'd21:  fib_weight = 16'd17711;
      32'd22:  fib_weight = 16'd28657;
      32'd23:  fib_weight = 16'd46368;
      default: fib_weight = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/ifns_tx_scheduler_enc.sv
// -----------------------------------------------------------------------------
// encoderIFNS_16di_core
// Combinational IFNS encoder: writes a 16-bit value in the Fibonacci numeral
// system (greedy, largest weight first). The greedy form never sets two
// adjacent bits, which is what bounds the crosstalk class on the coded bus.
//   din   in   16   raw data segment
//   dout  out  23   codeword d23..d1 (dout[i] = d_i)
// -----------------------------------------------------------------------------
module encoderIFNS_16di_core
  import ifns_pkg::*;
(
  input  logic [IFNS_DATA_W-1:0] din,
  output ifns_code_t             dout
);

  // Greedy Fibonacci decomposition from d23 down to d1.
  always_comb begin
    logic [IFNS_DATA_W-1:0] res_v;
    res_v = din;
    dout  = '0;
    for (int i = IFNS_CODE_W; i >= 1; i--) begin
      if (res_v >= fib_weight(i)) begin
        dout[i] = 1'b1;
        res_v   = res_v - fib_weight(i);
      end else begin
        dout[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ifns_tx_scheduler.sv
// -----------------------------------------------------------------------------
// ifns_tx_scheduler
// Takes NUM_SEG x 16-bit frames over valid/ready and emits one registered
// IFNS codeword per segment over valid/ready. The last codeword stays on the
// bus while idle so idle cycles add no coupling transitions.
//   clock, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready   frame handshake (in_ready is combinational)
//   in_data             frame payload, 16*NUM_SEG bits
//   flush               synchronous abort of pending frame and output word
//   code_valid/ready    codeword handshake
//   codeout             codeword bits [23:1]
//   code_last           codeword is the final segment of its frame
//   seg_idx             send-order index of the segment in codeout
// -----------------------------------------------------------------------------
module ifns_tx_scheduler
  import ifns_pkg::*;
#(
  parameter int NUM_SEG   = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                           clock,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IFNS_DATA_W*NUM_SEG-1:0] in_data,
  input  logic                           flush,
  output logic                           code_valid,
  input  logic                           code_ready,
  output ifns_code_t                     codeout,
  output logic                           code_last,
  output logic [$clog2(NUM_SEG):0]       seg_idx
);

  localparam int DATA_W = IFNS_DATA_W * NUM_SEG;
  localparam int IDX_W  = $clog2(NUM_SEG) + 1;
  localparam logic [IDX_W-1:0] SEG_CNT  = IDX_W'(NUM_SEG);
  localparam logic [IDX_W-1:0] SEG_LAST = IDX_W'(NUM_SEG - 1);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  logic [DATA_W-1:0]      buf_q, buf_d;
  logic [IDX_W-1:0]       rem_q, rem_d;
  logic [IDX_W-1:0]       nxt_q, nxt_d;
  ifns_code_t             code_q, code_d;
  logic                   code_valid_q, code_valid_d;
  logic                   code_last_q, code_last_d;
  logic [IDX_W-1:0]       seg_idx_q, seg_idx_d;

  phase_e                 phase_s;
  logic                   ld_s;
  logic                   in_ready_s;
  logic                   accept_s;
  logic [IDX_W-1:0]       sel_s;
  logic [IFNS_DATA_W-1:0] seg_s;
  ifns_code_t             enc_s;

  // Pick the buffered segment that goes out next, honouring the send order.
  always_comb begin
    sel_s = LSB_FIRST ? nxt_q : (SEG_LAST - nxt_q);
    seg_s = '0;
    for (int k = 0; k < NUM_SEG; k++) begin
      seg_s = (sel_s == IDX_W'(k)) ? buf_q[IFNS_DATA_W*k +: IFNS_DATA_W] : seg_s;
    end
  end

  encoderIFNS_16di_core u_enc (
    .din  (seg_s),
    .dout (enc_s)
  );

  // Phase decode and handshake qualifiers.
  always_comb begin
    if (rem_q == '0) begin
      phase_s = PH_IDLE;
    end else if (rem_q == ONE) begin
      phase_s = PH_LAST;
    end else begin
      phase_s = PH_BUSY;
    end
    ld_s = (phase_s != PH_IDLE) && (!code_valid_q || code_ready);
    // In LAST, a frame may land in the same cycle as the final load.
    case (phase_s)
      PH_IDLE: in_ready_s = !flush;
      PH_LAST: in_ready_s = !flush && ld_s;
      default: in_ready_s = 1'b0;
    endcase
    accept_s = in_valid && in_ready_s;
  end

  // Next-state computation for counters, frame buffer and output register.
  always_comb begin
    buf_d        = buf_q;
    rem_d        = rem_q;
    nxt_d        = nxt_q;
    code_d       = code_q;
    code_valid_d = code_valid_q;
    code_last_d  = code_last_q;
    seg_idx_d    = seg_idx_q;
    if (flush) begin
      // codeout and seg_idx keep their value so the bus does not toggle.
      rem_d        = '0;
      code_valid_d = 1'b0;
      code_last_d  = 1'b0;
    end else begin
      if (ld_s) begin
        code_d       = enc_s;
        code_valid_d = 1'b1;
        seg_idx_d    = nxt_q;
        code_last_d  = (phase_s == PH_LAST);
        rem_d        = rem_q - ONE;
        nxt_d        = nxt_q + ONE;
      end else if (code_valid_q && code_ready) begin
        code_valid_d = 1'b0;
        code_last_d  = 1'b0;
      end else begin
        code_valid_d = code_valid_q;
      end
      // A new frame overrides the decrement of a same-cycle final load.
      if (accept_s) begin
        buf_d = in_data;
        rem_d = SEG_CNT;
        nxt_d = '0;
      end else begin
        buf_d = buf_q;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      buf_q        <= '0;
      rem_q        <= '0;
      nxt_q        <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      code_last_q  <= 1'b0;
      seg_idx_q    <= '0;
    end else begin
      buf_q        <= buf_d;
      rem_q        <= rem_d;
      nxt_q        <= nxt_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      code_last_q  <= code_last_d;
      seg_idx_q    <= seg_idx_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign code_valid = code_valid_q;
  assign codeout    = code_q;
  assign code_last  = code_last_q;
  assign seg_idx    = seg_idx_q;

endmodule

// File: tb/tb_ifns_tx_scheduler.sv
module tb_ifns_tx_scheduler;

  localparam int NUM_SEG = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_n;
  logic        in_valid, in_ready, flush, code_valid, code_ready, code_last;
  logic [63:0] in_data;
  logic [23:1] codeout;
  logic [2:0]  seg_idx;

  // second instance: two segments, MS segment first
  logic        b_in_valid, b_in_ready, b_flush, b_code_valid, b_code_ready, b_code_last;
  logic [31:0] b_in_data;
  logic [23:1] b_codeout;
  logic [1:0]  b_seg_idx;

  ifns_tx_scheduler #(.NUM_SEG(NUM_SEG), .LSB_FIRST(1'b1)) u_dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .code_valid(code_valid),
    .code_ready(code_ready), .codeout(codeout), .code_last(code_last),
    .seg_idx(seg_idx)
  );

  ifns_tx_scheduler #(.NUM_SEG(2), .LSB_FIRST(1'b0)) u_dut2 (
    .clock(clock), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .flush(b_flush), .code_valid(b_code_valid),
    .code_ready(b_code_ready), .codeout(b_codeout), .code_last(b_code_last),
    .seg_idx(b_seg_idx)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fibonacci-numeral reference: weights 1,2,3,5,... chosen largest first.
  function automatic logic [23:1] ref_enc(input logic [15:0] v);
    int w [1:23];
    int r;
    logic [23:1] c;
    w[1] = 1;
    w[2] = 2;
    for (int i = 3; i <= 23; i++) w[i] = w[i-1] + w[i-2];
    r = int'(v);
    c = '0;
    for (int i = 23; i >= 1; i--) begin
      if (r >= w[i]) begin
        c[i] = 1'b1;
        r    = r - w[i];
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] seg_of(input logic [63:0] f, input int k);
    return f[16*k +: 16];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scoreboard monitor (mid-cycle sampling) ----------------
  typedef struct packed {
    logic [23:1] code;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic        prev_stall = 1'b0;
  logic [23:1] prev_code;
  logic [2:0]  prev_idx;
  logic        prev_last;

  always @(negedge clock) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", code_valid, 1'b1);
        chk("hold_code", codeout, prev_code);
        chk("hold_idx", seg_idx, prev_idx);
        chk("hold_last", code_last, prev_last);
      end
      if (code_valid && code_ready) begin
        chk("sb_expected_word", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_code", codeout, e.code);
          chk("sb_idx", seg_idx, e.idx);
          chk("sb_last", code_last, e.last);
        end
      end
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        for (int k = 0; k < NUM_SEG; k++) begin
          e.code = ref_enc(seg_of(in_data, k));
          e.idx  = 3'(k);
          e.last = (k == NUM_SEG - 1);
          exp_q.push_back(e);
        end
      end
      prev_stall = code_valid && !code_ready && !flush;
      prev_code  = codeout;
      prev_idx   = seg_idx;
      prev_last  = code_last;
    end
  end

  // ---------------- directed and random stimulus ----------------
  initial begin
    logic [63:0] f1, f2, f3, f4, f5, f6, f7;
    logic [10:0] exp_vld;
    logic [9:0]  exp_rdy;
    logic        acc;
    int          acc_n;
    f1 = 64'h0123_4567_89AB_CDEF;
    f2 = 64'hFFFF_0000_AAAA_5555;
    f3 = 64'h1357_9BDF_2468_ACE0;
    f4 = 64'hDEAD_BEEF_CAFE_F00D;
    f5 = 64'h1111_2222_3333_4444;
    f6 = 64'h8000_7FFF_0001_FFFE;
    f7 = 64'h0F0F_F0F0_5A5A_A5A5;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; code_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_flush = 1'b0; b_code_ready = 1'b0;

    // reset state
    @(negedge clock);
    chk("rst_codeout", codeout, 23'd0);
    chk("rst_valid", code_valid, 1'b0);
    chk("rst_last", code_last, 1'b0);
    chk("rst_idx", seg_idx, 3'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    step();
    rst_n = 1'b1;
    step();

    // MS-first, two-segment instance
    b_in_valid = 1'b1; b_in_data = 32'hAAAA_1234; b_code_ready = 1'b1;
    @(negedge clock); chk("b_in_ready", b_in_ready, 1'b1);
    step(); b_in_valid = 1'b0;
    @(negedge clock); chk("b_lat_valid", b_code_valid, 1'b0);
    step();
    @(negedge clock);
    chk("b_w0_code", b_codeout, ref_enc(16'hAAAA));
    chk("b_w0_idx", b_seg_idx, 2'd0);
    chk("b_w0_last", b_code_last, 1'b0);
    step();
    @(negedge clock);
    chk("b_w1_code", b_codeout, ref_enc(16'h1234));
    chk("b_w1_idx", b_seg_idx, 2'd1);
    chk("b_w1_last", b_code_last, 1'b1);
    step();

    // 1: single frame, LSB segment first
    in_valid = 1'b1; in_data = f1; code_ready = 1'b1;
    @(negedge clock); chk("t1_in_ready", in_ready, 1'b1);
    step(); in_valid = 1'b0;
    @(negedge clock); chk("t1_lat_valid", code_valid, 1'b0);
    for (int k = 0; k < NUM_SEG; k++) begin
      step();
      @(negedge clock);
      chk($sformatf("t1_valid%0d", k), code_valid, 1'b1);
      chk($sformatf("t1_code%0d", k), codeout, ref_enc(seg_of(f1, k)));
      chk($sformatf("t1_idx%0d", k), seg_idx, 3'(k));
      chk($sformatf("t1_last%0d", k), code_last, 64'(k == NUM_SEG - 1));
    end
    // 4: idle keeps the last codeword on the bus
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clock);
      chk("t4_idle_valid", code_valid, 1'b0);
      chk("t4_idle_code", codeout, ref_enc(16'h0123));
    end
    step();

    // 2: back-to-back frames, no bubble
    exp_rdy = 10'b11_0001_0001;
    exp_vld = 11'b011_1111_1100;
    acc_n = 0;
    in_valid = 1'b1; in_data = f2; code_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clock);
      if (c < 10) chk($sformatf("t2_rdy%0d", c), in_ready, exp_rdy[c]);
      chk($sformatf("t2_vld%0d", c), code_valid, exp_vld[c]);
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        acc_n++;
        if (acc_n == 1) in_data = f3;
        else in_valid = 1'b0;
      end
    end
    chk("t2_accepts", acc_n, 2);

    // 3: backpressure on the second codeword
    in_valid = 1'b1; in_data = f4; code_ready = 1'b1;
    @(negedge clock); chk("t3_in_ready", in_ready, 1'b1);
    step(); in_valid = 1'b0;
    @(negedge clock);
    step();
    @(negedge clock); chk("t3_w0_idx", seg_idx, 3'd0);
    step(); code_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t3_stall_valid", code_valid, 1'b1);
      chk("t3_stall_idx", seg_idx, 3'd1);
      chk("t3_stall_code", codeout, ref_enc(seg_of(f4, 1)));
      chk("t3_stall_in_ready", in_ready, 1'b0);
      step();
    end
    code_ready = 1'b1;
    repeat (5) step();
    @(negedge clock); chk("t3_drained", code_valid, 1'b0);
    step();

    // 5: flush after the second codeword is loaded
    in_valid = 1'b1; in_data = f5; code_ready = 1'b1;
    @(negedge clock);
    step(); in_valid = 1'b0;
    @(negedge clock);
    step();
    @(negedge clock);
    step(); flush = 1'b1;
    @(negedge clock);
    chk("t5_flush_in_ready", in_ready, 1'b0);
    chk("t5_pre_idx", seg_idx, 3'd1);
    step(); flush = 1'b0;
    @(negedge clock);
    chk("t5_valid", code_valid, 1'b0);
    chk("t5_last", code_last, 1'b0);
    chk("t5_code_hold", codeout, ref_enc(seg_of(f5, 1)));
    chk("t5_idle_in_ready", in_ready, 1'b1);
    step(); in_valid = 1'b1; in_data = f6;
    @(negedge clock); chk("t5_new_in_ready", in_ready, 1'b1);
    step(); in_valid = 1'b0;
    @(negedge clock);
    step();
    @(negedge clock);
    chk("t5_new_valid", code_valid, 1'b1);
    chk("t5_new_idx", seg_idx, 3'd0);
    chk("t5_new_code", codeout, ref_enc(seg_of(f6, 0)));
    repeat (5) step();

    // 6: asynchronous reset mid-frame
    in_valid = 1'b1; in_data = f7; code_ready = 1'b1;
    @(negedge clock);
    step(); in_valid = 1'b0;
    @(negedge clock);
    step();
    @(negedge clock);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_code", codeout, 23'd0);
    chk("t6_async_valid", code_valid, 1'b0);
    chk("t6_async_last", code_last, 1'b0);
    chk("t6_async_idx", seg_idx, 3'd0);
    @(posedge clock); #1 rst_n = 1'b1;
    @(negedge clock);
    chk("t6_in_ready", in_ready, 1'b1);
    chk("t6_valid", code_valid, 1'b0);
    repeat (3) step();

    // randomized traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_data    = {$urandom, $urandom};
      code_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid = 1'b0; code_ready = 1'b1;
    repeat (12) step();
    @(negedge clock);
    chk("rand_sb_empty", exp_q.size(), 0);
    chk("rand_idle_valid", code_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
